// File: rtl/input_debounce2.sv
// Two-channel push-button debouncer: 2-flop synchronizer plus a confirm-count FSM per channel.
// Optional rise/fall edge pulses are built when DEBOUNCE_EDGE_PULSE_EN is defined.

module input_debounce2_chan #(
    parameter int STABLE_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall
);

    // state     | meaning
    // STABLE_LO | clean=0, waiting for a high sample
    // CHK_HI    | clean=0, counting consecutive high samples
    // STABLE_HI | clean=1, waiting for a low sample
    // CHK_LO    | clean=1, counting consecutive low samples
    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHK_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CHK_LO    = 2'd3
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(STABLE_CYCLES - 1);

    logic   s1_q, s2_q;
    state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic   clean_q, clean_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        case (state_q)
            STABLE_LO: begin
                cnt_d = 8'd0;
                if (ena && s2_q) begin
                    state_d = CHK_HI;
                    cnt_d   = 8'd1;
                end
            end
            STABLE_HI: begin
                cnt_d = 8'd0;
                if (ena && !s2_q) begin
                    state_d = CHK_LO;
                    cnt_d   = 8'd1;
                end
            end
            CHK_HI: begin
                if (!ena || !s2_q) begin
                    state_d = STABLE_LO;
                    cnt_d   = 8'd0;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = STABLE_HI;
                    cnt_d   = 8'd0;
                    clean_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            CHK_LO: begin
                if (!ena || s2_q) begin
                    state_d = STABLE_HI;
                    cnt_d   = 8'd0;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = STABLE_LO;
                    cnt_d   = 8'd0;
                    clean_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = 8'd0;
                clean_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= STABLE_LO;
            cnt_q   <= 8'd0;
            clean_q <= 1'b0;
        end else begin
            s1_q    <= raw;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    assign clean = clean_q;

`ifdef DEBOUNCE_EDGE_PULSE_EN
    logic rise_q, rise_d, fall_q, fall_d;

    // Registered from the next-level compare so the pulse lines up with clean.
    always_comb begin
        rise_d = clean_d & ~clean_q;
        fall_d = ~clean_d & clean_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

module input_debounce2 #(
    parameter int STABLE_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic raw_a,
    input  logic raw_b,
    output logic clean_a,
    output logic clean_b,
    output logic rise_a,
    output logic rise_b,
    output logic fall_a,
    output logic fall_b
);

    input_debounce2_chan #(.STABLE_CYCLES(STABLE_CYCLES)) u_chan_a (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .raw   (raw_a),
        .clean (clean_a),
        .rise  (rise_a),
        .fall  (fall_a)
    );

    input_debounce2_chan #(.STABLE_CYCLES(STABLE_CYCLES)) u_chan_b (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .raw   (raw_b),
        .clean (clean_b),
        .rise  (rise_b),
        .fall  (fall_b)
    );

endmodule

// File: doc/input_debounce2.md
INPUT_DEBOUNCE2 -- requirements
Module: input_debounce2

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 8, meaning the number of consecutive mismatching synchronized samples needed to accept a new level; legal range 2..255.
REQ-002 The block SHALL have port clk, input, 1 bit, meaning the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, meaning the synchronous, active-high reset.
REQ-004 The block SHALL have port ena, input, 1 bit, meaning the debounce enable.
REQ-005 The block SHALL have port raw_a, input, 1 bit, meaning the asynchronous button/switch input, channel A.
REQ-006 The block SHALL have port raw_b, input, 1 bit, meaning the asynchronous button/switch input, channel B.
REQ-007 The block SHALL have port clean_a, output, 1 bit, meaning the debounced level of channel A, registered; it feeds the downstream AND tile.
REQ-008 The block SHALL have port clean_b, output, 1 bit, meaning the debounced level of channel B, registered.
REQ-009 The block SHALL have port rise_a / rise_b, output, 1 bit each, meaning a 1-cycle pulse on a clean 0->1 change.
REQ-010 The block SHALL have port fall_a / fall_b, output, 1 bit each, meaning a 1-cycle pulse on a clean 1->0 change.

Function
REQ-011 Each channel SHALL pass its raw input through a 2-flop synchronizer (s1, s2); only s2 is used by the logic that follows.
REQ-012 Each channel SHALL hold an 8-bit counter cnt; channels are fully independent, with no shared state.
REQ-013 Each channel SHALL implement states STABLE_LO, CHK_HI, STABLE_HI, CHK_LO; clean = 1 in STABLE_HI and CHK_LO, 0 otherwise.
REQ-014 In STABLE_LO with s2=1 and ena=1, the channel SHALL go to CHK_HI with cnt=1; in STABLE_HI with s2=0 and ena=1, it SHALL go to CHK_LO with cnt=1.
REQ-015 In CHK_x, if s2 still mismatches clean and cnt < STABLE_CYCLES-1, cnt SHALL increment.
REQ-016 In CHK_x, if s2 mismatches and cnt == STABLE_CYCLES-1, the channel SHALL move to the opposite STABLE state, flip clean on that same edge, and clear cnt.
REQ-017 In CHK_x, if s2 matches clean (glitch), the channel SHALL return to the originating STABLE state with cnt=0; no output change.
REQ-018 Latency: a clean raw step, held, SHALL appear on clean_x at the (2+STABLE_CYCLES)th rising edge counting the first edge that samples the new raw value as edge 1.
REQ-019 When ena=0, all CHK_x states SHALL return to their STABLE state and cnt SHALL be 0; clean_x SHALL hold its value; synchronizers keep running.
REQ-020 A raw pulse shorter than STABLE_CYCLES synchronized samples SHALL never change clean_x.
REQ-021 Simultaneous transitions on A and B SHALL be processed independently, with identical latency.
REQ-022 rise_x/fall_x SHALL assert in the same cycle clean_x changes and SHALL be low in every other cycle; there is no back-to-back pulse on one channel.

Reset
REQ-023 When rst=1 at a clk edge, s1, s2, cnt, and all outputs SHALL be set to 0, and state SHALL be set to STABLE_LO, for both channels.
REQ-024 rst SHALL take priority over ena and all inputs; reset mid-CHK SHALL abort the check with no pulse.
REQ-025 The first edge with rst=0 SHALL resume normal sampling; a raw input already high then SHALL produce clean=1 after the REQ-018 latency.

Configuration
REQ-026 With macro DEBOUNCE_EDGE_PULSE_EN defined, rise_a/rise_b/fall_a/fall_b SHALL be generated per REQ-009, REQ-010 and REQ-022.
REQ-027 Without DEBOUNCE_EDGE_PULSE_EN, those four ports SHALL still exist, tied constant 0, with no edge-detect registers instantiated; clean_x behaviour is unchanged.

Verification
REQ-028 Step response: STABLE_CYCLES=4, ena=1, raw_a 0->1 and held -> clean_a=1 at edge 6, with rise_a high for exactly that cycle (macro on).
REQ-029 Glitch: STABLE_CYCLES=4, raw_b high for 3 synchronized cycles then low -> clean_b stays 0 and no pulses occur.
REQ-030 Enable gating: raw_a high with ena=0 for 20 cycles -> clean_a=0; then ena=1 -> clean_a=1 after 4 further cycles, counted from the first edge with ena=1.
REQ-031 Reset mid-check: STABLE_CYCLES=8, rst=1 when cnt=5 -> next cycle all outputs 0 with state STABLE_LO; after release, clean_a=1 at edge 10.
REQ-032 Dual/fall: clean_a=clean_b=1, raw_a and raw_b drop together -> both clean outputs are 0 and fall_a=fall_b=1 on the same edge; with the macro undefined, all pulse ports stay 0 throughout.
